// File: rtl/mmio_out_pkg.sv
// -----------------------------------------------------------------------------
// mmio_out_pkg
//   Shared definitions for the memory-mapped output port:
//     ch_width()          - width of the channel tag, max(1, clog2(num_ch))
//     MMIO_OUT_ENTRY_T    - parameterised FIFO entry layout {channel, data},
//                           channel in the upper bits. A package cannot hold a
//                           typedef that depends on module parameters, so the
//                           layout is provided as a macro and instantiated as
//                           a typedef inside each user module.
//     MMIO_DEFAULT_BASE   - default address of channel 0
//     MMIO_DEFAULT_HALT   - default halt instruction address
// -----------------------------------------------------------------------------
`ifndef MMIO_OUT_ENTRY_T
`define MMIO_OUT_ENTRY_T(CW, DW) struct packed { logic [(CW)-1:0] channel; logic [(DW)-1:0] data; }
`endif

package mmio_out_pkg;

    localparam int unsigned MMIO_DEFAULT_BASE = 'hFF;
    localparam int unsigned MMIO_DEFAULT_HALT = 'hFF;

    // A single channel still needs a 1-bit tag so the port never has zero width.
    function automatic int unsigned ch_width(input int unsigned num_ch);
        if (num_ch <= 1) begin
            return 1;
        end
        return $clog2(num_ch);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered pointers and occupancy count.
//   A push while full is accepted only when a pop happens in the same cycle;
//   a pop while empty is ignored. data_o shows the head entry and is forced
//   to zero while empty, so it reads as zero straight after reset even though
//   the storage array itself is not reset.
//
// Parameters
//   WIDTH   - entry width in bits
//   DEPTH   - number of entries, power of two, >= 2
// Ports
//   clk      in   clock, all state on posedge
//   rst      in   asynchronous active-high reset (pointers/count only)
//   push_i   in   request to enqueue data_i
//   pop_i    in   request to dequeue the head entry
//   data_i   in   WIDTH  entry to enqueue
//   data_o   out  WIDTH  head entry (zero while empty)
//   full_o   out  count == DEPTH
//   empty_o  out  count == 0
//   count_o  out  clog2(DEPTH+1)  occupancy
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Pop is evaluated first so a full FIFO can accept a push in the cycle
    // its head leaves.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointers wrap by natural overflow.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mmio_out_port.sv
// -----------------------------------------------------------------------------
// mmio_out_port
//   Memory-mapped output peripheral on the CPU data bus. Snoops data-memory
//   writes; a write landing in [BASE_ADDR, BASE_ADDR+NUM_CH) is queued as
//   {channel, data} and streamed out over valid/ready. Also watches the
//   instruction pointer for HALT_ADDR and raises a sticky halt flag; once
//   halted no further writes are captured, but the queue keeps draining.
//
//   Optional build macro: MMIO_OUT_TRACE_EN (simulation only) prints each
//   accepted push, each dropped write and the rising edge of halted.
//   Behaviour of the logic is identical with or without it.
//
// Parameters
//   DATA_W, ADDR_W, NUM_CH, BASE_ADDR, DEPTH (power of two, >= 2), HALT_ADDR
// Ports
//   clk          in   clock, all state on posedge
//   rst          in   asynchronous active-high reset
//   memAddress   in   ADDR_W  CPU data address
//   memIn        in   DATA_W  CPU write data
//   memWrEnable  in   CPU write strobe
//   instAddress  in   ADDR_W  CPU instruction pointer
//   outValid     out  head entry available
//   outReady     in   consumer accepts head entry
//   outData      out  DATA_W  head entry data
//   outChannel   out  CH_W    head entry channel
//   fifoCount    out  clog2(DEPTH+1) occupancy
//   overflow     out  sticky: a captured write was dropped (queue full)
//   halted       out  sticky: halt address seen
//   done         out  halted and queue empty
// -----------------------------------------------------------------------------
module mmio_out_port
    import mmio_out_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned NUM_CH    = 1,
    parameter int unsigned BASE_ADDR = MMIO_DEFAULT_BASE,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned HALT_ADDR = MMIO_DEFAULT_HALT,
    localparam int unsigned CH_W     = ch_width(NUM_CH),
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] memAddress,
    input  logic [DATA_W-1:0] memIn,
    input  logic              memWrEnable,
    input  logic [ADDR_W-1:0] instAddress,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outData,
    output logic [CH_W-1:0]   outChannel,
    output logic [CNT_W-1:0]  fifoCount,
    output logic              overflow,
    output logic              halted,
    output logic              done
);

    typedef `MMIO_OUT_ENTRY_T(CH_W, DATA_W) entry_t;

    // Window bounds carry one extra bit so BASE_ADDR+NUM_CH may equal
    // 2^ADDR_W (e.g. a single channel at the top address) without wrapping.
    localparam logic [ADDR_W:0]   WIN_LO = (ADDR_W + 1)'(BASE_ADDR);
    localparam logic [ADDR_W:0]   WIN_HI = (ADDR_W + 1)'(BASE_ADDR + NUM_CH);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] HALT_A = ADDR_W'(HALT_ADDR);

    logic [ADDR_W:0] addr_ext;
    logic            addr_in_win;
    logic            hit;
    logic [CH_W-1:0] hit_ch;
    logic            halt_seen;
    logic            pop;
    logic            push_ok;
    logic            drop;

    logic            fifo_full;
    logic            fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    entry_t          wr_entry;
    entry_t          head_entry;

    logic            halted_q, halted_d;
    logic            overflow_q, overflow_d;

    // ---------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------
    assign addr_ext    = {1'b0, memAddress};
    assign addr_in_win = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);

    // halted_q is the registered flag, so a write in the very cycle the halt
    // address is first sampled is still captured.
    assign hit       = memWrEnable && addr_in_win && !halted_q;
    assign hit_ch    = CH_W'(memAddress - BASE_A);
    assign halt_seen = (instAddress == HALT_A);

    assign wr_entry.channel = hit_ch;
    assign wr_entry.data    = memIn;

    // Mirrors the FIFO's own accept rule; used for the overflow flag and trace.
    // pop depends only on registered state and outReady; outValid never
    // depends on outReady.
    assign pop     = !fifo_empty && outReady;
    assign push_ok = hit && (!fifo_full || pop);
    assign drop    = hit && fifo_full && !pop;

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (hit),
        .pop_i   (pop),
        .data_i  (wr_entry),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // ---------------------------------------------------------------------
    // Sticky status flags
    // ---------------------------------------------------------------------
    always_comb begin
        halted_d   = halted_q | halt_seen;
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            halted_q   <= halted_d;
            overflow_q <= overflow_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign outValid   = !fifo_empty;
    assign outData    = head_entry.data;
    assign outChannel = head_entry.channel;
    assign fifoCount  = fifo_count;
    assign overflow   = overflow_q;
    assign halted     = halted_q;
    assign done       = halted_q && fifo_empty;

`ifdef MMIO_OUT_TRACE_EN
    always @(posedge clk) begin
        if (!rst) begin
            if (push_ok) begin
                $display("output ch%0d: %0d", hit_ch, memIn);
            end
            if (drop) begin
                $display("overflow ch%0d: %0d", hit_ch, memIn);
            end
            if (halt_seen && !halted_q) begin
                $display("halted");
            end
        end
    end
`endif

endmodule
